// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Width of the step counter, which holds values up to width-1.
  function automatic int CNT_W(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, try subtracting the divisor.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   rem,
  input  logic             msb,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH:0]   rem_nxt,
  output logic             q_bit
);

  // The partial remainder is always below the divisor, so rem[WIDTH] is 0 and the
  // extra top bit only serves as the borrow/sign bit of the trial subtraction.
  logic [WIDTH+1:0] w_t;
  logic [WIDTH+1:0] w_d;

  assign w_t     = {rem, msb};
  assign w_d     = w_t - {2'b00, dvs};
  assign q_bit   = ~w_d[WIDTH+1];
  assign rem_nxt = q_bit ? w_d[WIDTH:0] : w_t[WIDTH:0];

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring unsigned divider: one quotient bit per clock, MSB first,
// start/done handshake, results held until the next completion.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);

  localparam int CW = CNT_W(WIDTH);

  div_state_t       r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_dvd, w_dvd_nxt;
  logic [WIDTH-1:0] r_dvs, w_dvs_nxt;
  logic [WIDTH:0]   r_rem, w_rem_nxt;
  // Only the WIDTH-1 newest quotient bits are kept; the oldest would shift out anyway.
  logic [WIDTH-2:0] r_quo, w_quo_nxt;
  logic [WIDTH-1:0] r_q, w_q_nxt;
  logic [WIDTH-1:0] r_r, w_r_nxt;
  logic             r_dbz, w_dbz_nxt;

  logic [WIDTH:0]   w_rem_step;
  logic             w_q_bit;
  logic [WIDTH-1:0] w_quo_shift;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (r_rem),
    .msb     (r_dvd[WIDTH-1]),
    .dvs     (r_dvs),
    .rem_nxt (w_rem_step),
    .q_bit   (w_q_bit)
  );

  assign w_quo_shift = {r_quo, w_q_bit};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_dbz   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dvd   <= w_dvd_nxt;
      r_dvs   <= w_dvs_nxt;
      r_rem   <= w_rem_nxt;
      r_quo   <= w_quo_nxt;
      r_q     <= w_q_nxt;
      r_r     <= w_r_nxt;
      r_dbz   <= w_dbz_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dvd_nxt   = r_dvd;
    w_dvs_nxt   = r_dvs;
    w_rem_nxt   = r_rem;
    w_quo_nxt   = r_quo;
    w_q_nxt     = r_q;
    w_r_nxt     = r_r;
    w_dbz_nxt   = r_dbz;

    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_dvd_nxt = a;
          w_dvs_nxt = b;
          w_rem_nxt = '0;
          w_quo_nxt = '0;
          if (b != '0) begin
            w_state_nxt = RUN;
            w_cnt_nxt   = CW'(WIDTH - 1);
          end else begin
            // Divide by zero completes immediately with the conventional saturated result.
            w_state_nxt = DONE;
            w_q_nxt     = '1;
            w_r_nxt     = a;
            w_dbz_nxt   = 1'b1;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end

      RUN: begin
        w_dvd_nxt = {r_dvd[WIDTH-2:0], 1'b0};
        w_rem_nxt = w_rem_step;
        w_quo_nxt = w_quo_shift[WIDTH-2:0];
        if (r_cnt == '0) begin
          w_state_nxt = DONE;
          w_q_nxt     = w_quo_shift;
          w_r_nxt     = w_rem_step[WIDTH-1:0];
          w_dbz_nxt   = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  assign busy        = (r_state == RUN);
  assign done        = (r_state == DONE);
  assign q           = r_q;
  assign r           = r_r;
  assign div_by_zero = r_dbz;

endmodule
